data_mem_ctrl: RTL and testbench

- Data-memory controller downstream of the processor top's data bus (DAD, DDT, MREQ, WRITE, SIZE).
- Holds an internal word-organised SRAM array and serves byte, halfword and word loads and stores.
- Inserts a programmable number of wait states, then acknowledges each access with a one-cycle active-low ACKD_n pulse.
- Flags misaligned or out-of-range accesses on BUS_ERR instead of touching memory.

---
 rtl/data_mem_ctrl_if.sv | 22 ++
 rtl/data_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Data-bus handshake between the processor and the data-memory controller.
// The bidirectional data bus DDT is a shared tri-state net, so it stays a
// plain inout port on the controller rather than a member of this bundle.
interface data_mem_ctrl_if;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD;
  logic        ACKD_n;
  logic        BUS_ERR;
  logic        busy;

  modport master (
    output MREQ, WRITE, SIZE, DAD,
    input  ACKD_n, BUS_ERR, busy
  );

  modport slave (
    input  MREQ, WRITE, SIZE, DAD,
    output ACKD_n, BUS_ERR, busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word-organised SRAM serving big-endian byte,
// halfword and word accesses with programmable wait states, a one-cycle
// active-low acknowledge and a bus-error flag for illegal accesses.
module data_mem_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_ctrl_if.slave   bus,
  inout  wire  [31:0]      DDT
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

  // Counter preset on entry to WAIT so the state lasts exactly WAIT_CYC cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_write;
  logic              r_fault;
  logic [31:0]       r_wdata;
  logic [3:0]        r_cnt;
  logic [31:0]       r_mem [2**ADDR_W];
  logic [31:0]       r_rdWord;

  logic              w_fault;
  logic [ADDR_W-1:0] w_rdIdx;
  logic [3:0]        w_be;
  logic [31:0]       w_wrLanes;
  logic [31:0]       w_rdData;
  logic              w_commit;

  // An access is illegal for a reserved size, misalignment, or an address past the array.
  assign w_fault = (bus.SIZE == 2'b11)
                 | ((bus.SIZE == 2'b01) && bus.DAD[0])
                 | ((bus.SIZE == 2'b00) && (bus.DAD[1:0] != 2'b00))
                 | (bus.DAD[31:ADDR_W+2] != '0);

  // With zero wait states the read is issued straight from the live address in IDLE.
  assign w_rdIdx = (r_state == IDLE) ? bus.DAD[ADDR_W+1:2] : r_addr;

  // Next-state logic for the access sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.MREQ) w_next = (WAIT_CYC > 0) ? WAIT : ACK;
      WAIT: if (r_cnt == 4'd0) w_next = ACK;
      ACK:  w_next = DONE;
      DONE: if (!bus.MREQ) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register, request capture and wait-state counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_off   <= 2'b00;
      r_size  <= 2'b00;
      r_write <= 1'b0;
      r_fault <= 1'b0;
      r_wdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && bus.MREQ) begin
        r_addr  <= bus.DAD[ADDR_W+1:2];
        r_off   <= bus.DAD[1:0];
        r_size  <= bus.SIZE;
        r_write <= bus.WRITE;
        r_fault <= w_fault;
        r_wdata <= DDT;
        r_cnt   <= WAIT_LOAD;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Store lane selection: big-endian, so offset 0 is the most significant byte.
  always_comb begin
    w_be      = 4'b0000;
    w_wrLanes = r_wdata;
    case (r_size)
      2'b00: w_be = 4'b1111;
      2'b01: begin
        w_be      = r_off[1] ? 4'b0011 : 4'b1100;
        w_wrLanes = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be      = 4'b1000 >> r_off;
        w_wrLanes = {4{r_wdata[7:0]}};
      end
      default: w_be = 4'b0000;
    endcase
  end

  // Load data: the addressed lanes right-justified and zero-extended; zero on a fault.
  always_comb begin
    w_rdData = 32'h0;
    case (r_size)
      2'b00: w_rdData = r_rdWord;
      2'b01: w_rdData = r_off[1] ? {16'h0, r_rdWord[15:0]} : {16'h0, r_rdWord[31:16]};
      2'b10: begin
        case (r_off)
          2'd0:    w_rdData = {24'h0, r_rdWord[31:24]};
          2'd1:    w_rdData = {24'h0, r_rdWord[23:16]};
          2'd2:    w_rdData = {24'h0, r_rdWord[15:8]};
          default: w_rdData = {24'h0, r_rdWord[7:0]};
        endcase
      end
      default: w_rdData = 32'h0;
    endcase
    if (r_fault) w_rdData = 32'h0;
  end

  // A store commits only at the edge that ends ACK; reset forces IDLE so an aborted access never writes.
  assign w_commit = rst && (r_state == ACK) && r_write && !r_fault;

  // Array read registered on the edge entering ACK, plus byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_next == ACK) begin
      r_rdWord <= r_mem[w_rdIdx];
    end
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[r_addr][i*8 +: 8] <= w_wrLanes[i*8 +: 8];
      end
    end
  end

  assign bus.ACKD_n  = (r_state != ACK);
  assign bus.BUS_ERR = (r_state == ACK) && r_fault;
  assign bus.busy    = (r_state != IDLE);
  assign DDT         = ((r_state == ACK) && !r_write) ? w_rdData : 32'hz;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl with hand-computed expected values.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbDrv;
  logic [31:0] tbData;
  wire  [31:0] DDT;
  int          compared   = 0;
  int          mismatched = 0;

  data_mem_ctrl_if bus();

  assign DDT = tbDrv ? tbData : 32'hz;

  data_mem_ctrl #(.ADDR_W(10), .WAIT_CYC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .DDT (DDT)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop if the bench ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access, started at a falling edge; returns read data, error flag,
  // latency in cycles from the sampling edge, and ACK pulses seen while MREQ is held on.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                               input logic [31:0] wd, input int hold,
                               output logic [31:0] rd, output logic err,
                               output int lat, output int extraAcks);
    logic gotAck;
    bus.MREQ  = 1'b1;
    bus.WRITE = wr;
    bus.SIZE  = sz;
    bus.DAD   = addr;
    tbDrv     = wr;
    tbData    = wd;
    lat       = 0;
    extraAcks = 0;
    gotAck    = 1'b0;
    rd        = 32'h0;
    err       = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      lat++;
      if (!bus.ACKD_n) begin
        gotAck = 1'b1;
        break;
      end
      bus.DAD = ~addr;
      tbData  = ~wd;
    end
    checkOutput("ackSeen", {31'b0, gotAck}, 32'd1);
    rd  = DDT;
    err = bus.BUS_ERR;
    for (int n = 0; n < hold; n++) begin
      @(negedge clk);
      if (!bus.ACKD_n) extraAcks++;
    end
    bus.MREQ = 1'b0;
    tbDrv    = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    checkOutput("backToIdle", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          ex;

    rst       = 1'b1;
    tbDrv     = 1'b0;
    tbData    = 32'h0;
    bus.MREQ  = 1'b0;
    bus.WRITE = 1'b0;
    bus.SIZE  = 2'b00;
    bus.DAD   = 32'h0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rstAckdN",  {31'b0, bus.ACKD_n},  32'd1);
    checkOutput("rstBusErr", {31'b0, bus.BUS_ERR}, 32'd0);
    checkOutput("rstBusy",   {31'b0, bus.busy},    32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] word store / load");
    applyStimulus(1'b1, 2'b00, 32'h10, 32'h12345678, 0, rd, err, lat, ex);
    checkOutput("stWordLat", lat, 32'd2);
    checkOutput("stWordErr", {31'b0, err}, 32'd0);
    applyStimulus(1'b0, 2'b00, 32'h10, 32'h0, 0, rd, err, lat, ex);
    checkOutput("ldWordLat",  lat, 32'd2);
    checkOutput("ldWordData", rd, 32'h12345678);
    checkOutput("ldWordErr",  {31'b0, err}, 32'd0);

    $display("[TB] byte lanes");
    applyStimulus(1'b1, 2'b10, 32'h11, 32'h000000AB, 0, rd, err, lat, ex);
    checkOutput("stByteErr", {31'b0, err}, 32'd0);
    applyStimulus(1'b0, 2'b00, 32'h10, 32'h0, 0, rd, err, lat, ex);
    checkOutput("wordAfterByte", rd, 32'h12AB5678);
    applyStimulus(1'b0, 2'b10, 32'h13, 32'h0, 0, rd, err, lat, ex);
    checkOutput("ldByte3", rd, 32'h00000078);
    applyStimulus(1'b0, 2'b10, 32'h11, 32'h0, 0, rd, err, lat, ex);
    checkOutput("ldByte1", rd, 32'h000000AB);
    applyStimulus(1'b0, 2'b10, 32'h10, 32'h0, 0, rd, err, lat, ex);
    checkOutput("ldByte0", rd, 32'h00000012);

    $display("[TB] halfword lanes");
    applyStimulus(1'b1, 2'b00, 32'h20, 32'h00000000, 0, rd, err, lat, ex);
    applyStimulus(1'b1, 2'b01, 32'h22, 32'h0000BEEF, 0, rd, err, lat, ex);
    checkOutput("stHalfErr", {31'b0, err}, 32'd0);
    applyStimulus(1'b0, 2'b00, 32'h20, 32'h0, 0, rd, err, lat, ex);
    checkOutput("wordAfterHalf", rd, 32'h0000BEEF);
    applyStimulus(1'b0, 2'b01, 32'h20, 32'h0, 0, rd, err, lat, ex);
    checkOutput("ldHalf0", rd, 32'h00000000);
    applyStimulus(1'b0, 2'b01, 32'h22, 32'h0, 0, rd, err, lat, ex);
    checkOutput("ldHalf2", rd, 32'h0000BEEF);

    $display("[TB] faulting accesses");
    applyStimulus(1'b0, 2'b00, 32'h06, 32'h0, 0, rd, err, lat, ex);
    checkOutput("misWordErr",  {31'b0, err}, 32'd1);
    checkOutput("misWordData", rd, 32'h0);
    checkOutput("misWordLat",  lat, 32'd2);
    applyStimulus(1'b1, 2'b00, 32'h30, 32'hCAFEF00D, 0, rd, err, lat, ex);
    applyStimulus(1'b1, 2'b01, 32'h31, 32'h00005555, 0, rd, err, lat, ex);
    checkOutput("misHalfErr", {31'b0, err}, 32'd1);
    applyStimulus(1'b0, 2'b11, 32'h30, 32'h0, 0, rd, err, lat, ex);
    checkOutput("rsvdLdErr",  {31'b0, err}, 32'd1);
    checkOutput("rsvdLdData", rd, 32'h0);
    applyStimulus(1'b1, 2'b11, 32'h30, 32'hFFFFFFFF, 0, rd, err, lat, ex);
    checkOutput("rsvdStErr", {31'b0, err}, 32'd1);
    applyStimulus(1'b0, 2'b00, 32'h30, 32'h0, 0, rd, err, lat, ex);
    checkOutput("word30Kept", rd, 32'hCAFEF00D);
    checkOutput("word30Err",  {31'b0, err}, 32'd0);

    $display("[TB] out-of-range address");
    applyStimulus(1'b1, 2'b00, 32'h00, 32'h00000000, 0, rd, err, lat, ex);
    applyStimulus(1'b1, 2'b00, 32'h00001000, 32'h77777777, 0, rd, err, lat, ex);
    checkOutput("oorStErr", {31'b0, err}, 32'd1);
    applyStimulus(1'b0, 2'b00, 32'h00001000, 32'h0, 0, rd, err, lat, ex);
    checkOutput("oorLdErr",  {31'b0, err}, 32'd1);
    checkOutput("oorLdData", rd, 32'h0);
    applyStimulus(1'b0, 2'b00, 32'h00, 32'h0, 0, rd, err, lat, ex);
    checkOutput("word0Kept", rd, 32'h0);

    $display("[TB] MREQ held after ACK, then one-cycle gap");
    applyStimulus(1'b1, 2'b00, 32'h50, 32'h11111111, 10, rd, err, lat, ex);
    checkOutput("holdExtraAcks", ex, 32'd0);
    applyStimulus(1'b0, 2'b00, 32'h50, 32'h0, 0, rd, err, lat, ex);
    checkOutput("reraiseLat",  lat, 32'd2);
    checkOutput("reraiseData", rd, 32'h11111111);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 2'b00, 32'h40, 32'hA5A5A5A5, 0, rd, err, lat, ex);
    bus.MREQ  = 1'b1;
    bus.WRITE = 1'b1;
    bus.SIZE  = 2'b00;
    bus.DAD   = 32'h40;
    tbDrv     = 1'b1;
    tbData    = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("busyInWait", {31'b0, bus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("abortAckdN", {31'b0, bus.ACKD_n}, 32'd1);
    checkOutput("abortBusy",  {31'b0, bus.busy},   32'd0);
    @(negedge clk);
    checkOutput("abortAckdN2", {31'b0, bus.ACKD_n}, 32'd1);
    bus.MREQ = 1'b0;
    tbDrv    = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h40, 32'h0, 0, rd, err, lat, ex);
    checkOutput("word40Kept", rd, 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
